fisr_iter_scheduler: RTL and testbench
======================================

Name: fisr_iter_scheduler

Overview:
- Front-end controller for the fast-inverse-square-root datapath.
- Accepts float32 requests, forms the magic-constant initial guess y0 and the half-operand x/2, and issues them to an external fixed-latency Newton-Raphson iteration pipeline (multiply / subtract-from-1.5 / multiply).
- Recirculates each result for ITERS passes, then delivers it in-order-of-completion through a valid/ready output.
- Tracks contexts in a slot table so several requests overlap in the pipeline.

Parameters:
- DEPTH, 4: number of context slots; maximum requests in flight, including results waiting at the output.
- LAT, 8: exact datapath latency in cycles, from iss_valid to the matching ret value; at least 2.
- ITERS, 1: Newton-Raphson passes per request; at least 1.
- TAGW, 4: width of the user tag.
- MAGIC, 32'h5F3759DF: initial-guess constant.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_x  in  32  float32 operand
- in_tag  in  TAGW  user tag, returned with the result
- iss_valid  out  1  issue one operand set to the datapath
- iss_y  out  32  current estimate y_k
- iss_xhalf  out  32  x/2
- ret_y  in  32  datapath result y_{k+1}; sampled exactly LAT cycles after iss_valid
- out_valid  out  1  result valid
- out_ready  in  1  result consumer ready
- out_y  out  32  final 1/sqrt(x)
- out_tag  out  TAGW  tag of the result
- out_err  out  1  input was special (negative, zero, denormal, inf or NaN)
- busy  out  1  at least one slot occupied

Behaviour:
- Reset (rst low, async):
  - All slots free; shadow pipe cleared; output FIFO empty.
  - in_ready=0, iss_valid=0, out_valid=0, busy=0; out_y, out_tag, out_err = 0.
  - in_ready may rise on the first clock edge after release.
  - Reset mid-operation drops all contexts. ret_y is ignored until the shadow pipe refills.
- Slot table, per entry: occupied, xhalf[31:0], tag, iteration count (ceil(log2(ITERS+1)) bits). The lowest-index free slot is allocated.
- Shadow pipe: LAT stages of {valid, slot}, shifted every cycle. Stage LAT-1 is a return event and samples ret_y.
- Initial values:
  - y0 = MAGIC - {1'b0, in_x[31:1]}, 32-bit modular.
  - xhalf = {in_x[31], in_x[30:23]-1, in_x[22:0]}.
- Special inputs:
  - Conditions: sign=1, exp=0, or exp=255.
  - Allocate a slot, are never issued, and are written to the output FIFO in the accept cycle with out_err=1.
  - out_y = 7FC00000 for negative or NaN; 7F800000 for ±0 or denormal (positive sign); 00000000 for +inf.
- Issue arbitration, one issue per cycle:
  1. Recirculation has priority. On a return event with count+1 < ITERS: reissue the same cycle with iss_y=ret_y and the stored xhalf; increment count.
  2. On a return event with count+1 == ITERS: push {ret_y, tag, err=0} into the output FIFO.
  3. Otherwise a new non-special accepted request issues with y0; count=0.
- in_ready = (free slot exists) && !(return event this cycle). in_ready is combinational from registered state only; it does not depend on in_valid.
- Output FIFO:
  - Depth DEPTH; at most one write per cycle, guaranteed by in_ready.
  - Never overflows, because slots ≥ FIFO entries.
  - out_* presents the FIFO head. A slot is freed on an out_valid && out_ready handshake.
  - Freed slot is usable the next cycle.
  - With FIFO empty, a write makes out_valid high the next cycle.
- out_valid holds with stable data until accepted.
- busy = OR of occupied bits.
- Simultaneous handshake-free and allocate in the same cycle: allocation sees the pre-free state (no same-cycle reuse).
- Minimum latency, accept to out_valid: ITERS*LAT + 1 cycles.
- Special inputs: out_valid high 1 cycle after accept.

Test Plan:
- Single request, LAT=8, ITERS=1, model datapath returns 3EFFFFF0. Send in_x=40800000 (4.0), tag=3 -> iss_valid the cycle after accept with iss_y=3EF759DF and iss_xhalf=40000000. out_valid 9 cycles after accept with out_y=3EFFFFF0, tag=3, err=0.
- ITERS=2, model returns its input + 1 -> first return reissued the same cycle with iss_y=3EF759E0. Final out_y=3EF759E1 at 17 cycles after accept.
- Specials: in_x=BF800000, then 00000000, then 7F800000 -> outputs 7FC00000, 7F800000, 00000000 in order, err=1, no iss_valid pulses.
- Fill: DEPTH=4 back-to-back requests with out_ready=0 -> in_ready low after the 4th accept. Results held, 4 out_valid beats drained in completion order once out_ready=1. in_ready high the cycle after the first handshake.
- Contention, ITERS=2: a return event coincides with in_valid -> in_ready=0 that cycle. New request accepted the next cycle. No lost or duplicated issue.
- Assert rst low while 3 requests are in flight -> all outputs 0 immediately. After release, stale ret_y ignored. A new request completes normally.

Source files
------------

// File: rtl/fisr_iter_scheduler.sv
// Front-end for the fast inverse square root Newton-Raphson datapath: forms y0 and x/2,
// tracks contexts in a slot table and recirculates each estimate ITERS times before output.
module fisr_iter_scheduler #(
  parameter int          DEPTH = 4,
  parameter int          LAT   = 8,
  parameter int          ITERS = 1,
  parameter int          TAGW  = 4,
  parameter logic [31:0] MAGIC = 32'h5F3759DF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_x,
  input  logic [TAGW-1:0] in_tag,
  output logic            iss_valid,
  output logic [31:0]     iss_y,
  output logic [31:0]     iss_xhalf,
  input  logic [31:0]     ret_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_y,
  output logic [TAGW-1:0] out_tag,
  output logic            out_err,
  output logic            busy
);
  localparam int SW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(ITERS + 1);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] occ;
  logic [31:0]      slot_xhalf [DEPTH];
  logic [TAGW-1:0]  slot_tag   [DEPTH];
  logic [CW-1:0]    slot_cnt   [DEPTH];

  logic [LAT-1:0]   pipe_valid;
  logic [SW-1:0]    pipe_slot  [LAT];

  logic [31:0]      fifo_y     [DEPTH];
  logic [TAGW-1:0]  fifo_tag   [DEPTH];
  logic             fifo_err   [DEPTH];
  logic [SW-1:0]    fifo_slot  [DEPTH];
  logic [SW-1:0]    rd_ptr, wr_ptr;
  logic [CNTW-1:0]  fifo_cnt;
  logic             ready_en;

  logic             ret_event, ret_last;
  logic [SW-1:0]    ret_slot, free_slot;
  logic             free_found, accept, special;
  logic [7:0]       x_exp;
  logic [22:0]      x_frac;
  logic [31:0]      special_y, y0, xhalf_new;
  logic             issue_recirc, issue_new, fifo_wr, fifo_rd;
  logic [31:0]      wr_y;
  logic [TAGW-1:0]  wr_tag;
  logic [SW-1:0]    wr_slot;

  function automatic logic [SW-1:0] ptr_inc(input logic [SW-1:0] p);
    return (p == SW'(DEPTH - 1)) ? '0 : p + SW'(1);
  endfunction

  assign ret_event = pipe_valid[LAT-1];
  assign ret_slot  = pipe_slot[LAT-1];
  assign ret_last  = (int'(slot_cnt[ret_slot]) + 1) >= ITERS;

  assign x_exp     = in_x[30:23];
  assign x_frac    = in_x[22:0];
  assign special   = in_x[31] || (x_exp == 8'h00) || (x_exp == 8'hFF);
  assign y0        = MAGIC - {1'b0, in_x[31:1]};
  assign xhalf_new = {in_x[31], x_exp - 8'd1, x_frac};

  always_comb begin
    free_found = 1'b0;
    free_slot  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!occ[i]) begin
        free_found = 1'b1;
        free_slot  = SW'(i);
      end
    end
  end

  // Zero of either sign maps to +inf; any other negative or NaN maps to qNaN; +inf maps to 0.
  always_comb begin
    special_y = 32'h0000_0000;
    if (x_exp == 8'hFF && x_frac != 23'd0)      special_y = 32'h7FC0_0000;
    else if (x_exp == 8'h00 && x_frac == 23'd0) special_y = 32'h7F80_0000;
    else if (in_x[31])                          special_y = 32'h7FC0_0000;
    else if (x_exp == 8'h00)                    special_y = 32'h7F80_0000;
  end

  assign in_ready     = ready_en && free_found && !ret_event;
  assign accept       = in_valid && in_ready;
  assign issue_recirc = ret_event && !ret_last;
  assign issue_new    = accept && !special;
  assign fifo_wr      = (ret_event && ret_last) || (accept && special);
  assign fifo_rd      = out_valid && out_ready;

  assign wr_y    = ret_event ? ret_y : special_y;
  assign wr_tag  = ret_event ? slot_tag[ret_slot] : in_tag;
  assign wr_slot = ret_event ? ret_slot : free_slot;

  assign out_valid = (fifo_cnt != '0);
  assign out_y     = out_valid ? fifo_y[rd_ptr]   : '0;
  assign out_tag   = out_valid ? fifo_tag[rd_ptr] : '0;
  assign out_err   = out_valid ? fifo_err[rd_ptr] : 1'b0;
  assign busy      = |occ;

  // Allocation and release touch different slots, so the same-cycle case needs no ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en   <= 1'b0;
      occ        <= '0;
      pipe_valid <= '0;
      iss_valid  <= 1'b0;
      iss_y      <= '0;
      iss_xhalf  <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_xhalf[i] <= '0;
        slot_tag[i]   <= '0;
        slot_cnt[i]   <= '0;
        fifo_y[i]     <= '0;
        fifo_tag[i]   <= '0;
        fifo_err[i]   <= 1'b0;
        fifo_slot[i]  <= '0;
      end
      for (int i = 0; i < LAT; i++) pipe_slot[i] <= '0;
    end else begin
      ready_en <= 1'b1;

      if (accept) begin
        occ[free_slot]        <= 1'b1;
        slot_xhalf[free_slot] <= xhalf_new;
        slot_tag[free_slot]   <= in_tag;
        slot_cnt[free_slot]   <= '0;
      end
      if (issue_recirc) slot_cnt[ret_slot] <= slot_cnt[ret_slot] + CW'(1);
      if (fifo_rd) occ[fifo_slot[rd_ptr]] <= 1'b0;

      pipe_valid   <= {pipe_valid[LAT-2:0], issue_recirc || issue_new};
      pipe_slot[0] <= issue_recirc ? ret_slot : free_slot;
      for (int i = 1; i < LAT; i++) pipe_slot[i] <= pipe_slot[i-1];

      iss_valid <= issue_recirc || issue_new;
      iss_y     <= issue_recirc ? ret_y : y0;
      iss_xhalf <= issue_recirc ? slot_xhalf[ret_slot] : xhalf_new;

      if (fifo_wr) begin
        fifo_y[wr_ptr]    <= wr_y;
        fifo_tag[wr_ptr]  <= wr_tag;
        fifo_err[wr_ptr]  <= !ret_event;
        fifo_slot[wr_ptr] <= wr_slot;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (fifo_rd) rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CNTW'(fifo_wr) - CNTW'(fifo_rd);
    end
  end
endmodule

// File: tb/tb_fisr_iter_scheduler.sv
// Bench for fisr_iter_scheduler: one instance with ITERS=1 (constant datapath) and one with
// ITERS=2 (datapath adds 1), checked against a result scoreboard and directed timing checks.
module tb_fisr_iter_scheduler;
  localparam int LAT = 8;
  localparam logic [31:0] MAGIC = 32'h5F3759DF;

  typedef struct packed {
    logic [31:0] y;
    logic [3:0]  tag;
    logic        err;
  } res_t;

  logic        clk;
  logic        rst;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_x      [2];
  logic [3:0]  in_tag    [2];
  logic        iss_valid [2];
  logic [31:0] iss_y     [2];
  logic [31:0] iss_xhalf [2];
  logic [31:0] ret_y     [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_y     [2];
  logic [3:0]  out_tag   [2];
  logic        out_err   [2];
  logic        busy      [2];

  res_t        exp_q0[$];
  res_t        exp_q1[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_cyc [2];
  int          iss_cnt [2];
  logic [31:0] dl0 [LAT-1];
  logic [31:0] dl1 [LAT-1];

  fisr_iter_scheduler #(.DEPTH(4), .LAT(LAT), .ITERS(1), .TAGW(4), .MAGIC(MAGIC)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_x(in_x[0]), .in_tag(in_tag[0]),
    .iss_valid(iss_valid[0]), .iss_y(iss_y[0]), .iss_xhalf(iss_xhalf[0]), .ret_y(ret_y[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_y(out_y[0]), .out_tag(out_tag[0]),
    .out_err(out_err[0]), .busy(busy[0])
  );

  fisr_iter_scheduler #(.DEPTH(4), .LAT(LAT), .ITERS(2), .TAGW(4), .MAGIC(MAGIC)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_x(in_x[1]), .in_tag(in_tag[1]),
    .iss_valid(iss_valid[1]), .iss_y(iss_y[1]), .iss_xhalf(iss_xhalf[1]), .ret_y(ret_y[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_y(out_y[1]), .out_tag(out_tag[1]),
    .out_err(out_err[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-ins: an operand captured at an edge comes back LAT edges after the
  // scheduler decided to issue it, i.e. LAT-1 edges after iss_valid is seen.
  always @(posedge clk) begin
    dl0[0] <= 32'h3EFF_FFF0;
    dl1[0] <= iss_y[1] + 32'd1;
    for (int i = 1; i < LAT - 1; i++) begin
      dl0[i] <= dl0[i-1];
      dl1[i] <= dl1[i-1];
    end
  end
  assign ret_y[0] = dl0[LAT-2];
  assign ret_y[1] = dl1[LAT-2];

  function automatic res_t model(input int d, input logic [31:0] x, input logic [3:0] tag);
    res_t r;
    r.tag = tag;
    r.err = 1'b1;
    if (x[30:23] == 8'hFF && x[22:0] != 23'd0)      r.y = 32'h7FC0_0000;
    else if (x[30:0] == 31'd0)                      r.y = 32'h7F80_0000;
    else if (x[31])                                 r.y = 32'h7FC0_0000;
    else if (x[30:23] == 8'h00)                     r.y = 32'h7F80_0000;
    else if (x[30:23] == 8'hFF)                     r.y = 32'h0000_0000;
    else begin
      r.err = 1'b0;
      r.y   = (d == 0) ? 32'h3EFF_FFF0 : (MAGIC - (x >> 1)) + 32'd2;
    end
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %h, want %h", name, obs, exp);
    end
  endtask

  task automatic pop_check(input int d);
    res_t r;
    int   n;
    n = (d == 0) ? exp_q0.size() : exp_q1.size();
    check_output("sb_pending", 32'(n != 0), 32'd1);
    if (n != 0) begin
      r = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check_output("out_y", out_y[d], r.y);
      check_output("out_tag", 32'(out_tag[d]), 32'(r.tag));
      check_output("out_err", 32'(out_err[d]), 32'(r.err));
    end
  endtask

  // Records what the upcoming edge will do, then advances to just after it.
  task automatic cycle();
    for (int d = 0; d < 2; d++) begin
      if (in_valid[d] && in_ready[d]) begin
        if (d == 0) exp_q0.push_back(model(0, in_x[0], in_tag[0]));
        else        exp_q1.push_back(model(1, in_x[1], in_tag[1]));
        acc_cyc[d] = cyc;
      end
      if (out_valid[d] && out_ready[d]) pop_check(d);
      if (iss_valid[d]) iss_cnt[d]++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_stimulus(input int d, input logic [31:0] x, input logic [3:0] tag);
    int n = 0;
    in_valid[d] = 1'b1;
    in_x[d]     = x;
    in_tag[d]   = tag;
    while (!in_ready[d] && n < 50) begin
      cycle();
      n++;
    end
    check_output("accept_wait", 32'(n < 50), 32'd1);
    cycle();
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_out(input int d, input int budget);
    int n = 0;
    while (!out_valid[d] && n < budget) begin
      cycle();
      n++;
    end
    check_output("out_wait", 32'(out_valid[d]), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [31:0] specials [4];
    int          iss_base;
    int          first_iss;

    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      in_x[d]      = '0;
      in_tag[d]    = '0;
      out_ready[d] = 1'b1;
      acc_cyc[d]   = 0;
      iss_cnt[d]   = 0;
    end

    #3;
    for (int d = 0; d < 2; d++) begin
      check_output("rst_in_ready", 32'(in_ready[d]), 32'd0);
      check_output("rst_iss_valid", 32'(iss_valid[d]), 32'd0);
      check_output("rst_out_valid", 32'(out_valid[d]), 32'd0);
      check_output("rst_busy", 32'(busy[d]), 32'd0);
      check_output("rst_out_y", out_y[d], 32'd0);
    end
    #4 rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("ready_after_rst", 32'(in_ready[0]), 32'd1);

    // Single request through the ITERS=1 instance.
    $display("[TB] single request");
    apply_stimulus(0, 32'h4080_0000, 4'd3);
    check_output("iss_valid_t1", 32'(iss_valid[0]), 32'd1);
    check_output("iss_y_t1", iss_y[0], 32'h3EF7_59DF);
    check_output("iss_xhalf_t1", iss_xhalf[0], 32'h4000_0000);
    wait_out(0, 30);
    check_output("lat_iters1", 32'(cyc - acc_cyc[0]), 32'd9);
    idle(2);
    check_output("iss_count_t1", 32'(iss_cnt[0]), 32'd1);

    // Two passes: the first result must come back as the next estimate.
    $display("[TB] two iterations");
    apply_stimulus(1, 32'h4080_0000, 4'd5);
    check_output("iss_y_t2a", iss_y[1], 32'h3EF7_59DF);
    first_iss = cyc;
    cycle();
    for (int n = 0; n < 30 && !iss_valid[1]; n++) cycle();
    check_output("reissue_gap", 32'(cyc - first_iss), 32'(LAT));
    check_output("iss_y_t2b", iss_y[1], 32'h3EF7_59E0);
    check_output("iss_xhalf_t2b", iss_xhalf[1], 32'h4000_0000);
    wait_out(1, 30);
    check_output("lat_iters2", 32'(cyc - acc_cyc[1]), 32'd17);
    idle(2);

    // Special operands bypass the datapath entirely.
    $display("[TB] special operands");
    specials[0] = 32'hBF80_0000;
    specials[1] = 32'h0000_0000;
    specials[2] = 32'h7F80_0000;
    specials[3] = 32'h7FC0_0000;
    iss_base = iss_cnt[0];
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(0, specials[k], 4'(k + 1));
      check_output("special_out_valid", 32'(out_valid[0]), 32'd1);
    end
    idle(LAT + 2);
    check_output("special_no_issue", 32'(iss_cnt[0] - iss_base), 32'd0);
    check_output("special_drained", 32'(exp_q0.size()), 32'd0);

    // Fill every slot while the consumer stalls.
    $display("[TB] fill");
    out_ready[0] = 1'b0;
    for (int k = 0; k < 4; k++) apply_stimulus(0, 32'h3F80_0000 + (32'(k) << 23), 4'(k + 8));
    check_output("full_in_ready", 32'(in_ready[0]), 32'd0);
    check_output("full_busy", 32'(busy[0]), 32'd1);
    idle(12);
    check_output("held_out_valid", 32'(out_valid[0]), 32'd1);
    check_output("held_in_ready", 32'(in_ready[0]), 32'd0);
    out_ready[0] = 1'b1;
    cycle();
    check_output("freed_in_ready", 32'(in_ready[0]), 32'd1);
    idle(3);
    check_output("fill_drained_valid", 32'(out_valid[0]), 32'd0);
    check_output("fill_drained_busy", 32'(busy[0]), 32'd0);
    check_output("fill_sb_empty", 32'(exp_q0.size()), 32'd0);

    // A return event blocks a new request for exactly that cycle.
    $display("[TB] contention");
    iss_base = iss_cnt[1];
    apply_stimulus(1, 32'h3F80_0000, 4'd1);
    idle(LAT - 1);
    in_valid[1] = 1'b1;
    in_x[1]     = 32'h4100_0000;
    in_tag[1]   = 4'd2;
    check_output("contend_blocked", 32'(in_ready[1]), 32'd0);
    cycle();
    check_output("contend_ready", 32'(in_ready[1]), 32'd1);
    cycle();
    in_valid[1] = 1'b0;
    idle(3 * LAT);
    check_output("contend_issues", 32'(iss_cnt[1] - iss_base), 32'd4);
    check_output("contend_sb_empty", 32'(exp_q1.size()), 32'd0);

    // Asynchronous reset with work in flight, then stale returns must be ignored.
    $display("[TB] reset mid-flight");
    for (int k = 0; k < 3; k++) apply_stimulus(1, 32'h4080_0000, 4'(k + 4));
    idle(3);
    #2 rst = 1'b0;
    #1;
    check_output("midrst_in_ready", 32'(in_ready[1]), 32'd0);
    check_output("midrst_iss_valid", 32'(iss_valid[1]), 32'd0);
    check_output("midrst_out_valid", 32'(out_valid[1]), 32'd0);
    check_output("midrst_busy", 32'(busy[1]), 32'd0);
    check_output("midrst_out_y", out_y[1], 32'd0);
    exp_q1.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    idle(LAT + 2);
    check_output("stale_out_valid", 32'(out_valid[1]), 32'd0);
    check_output("stale_busy", 32'(busy[1]), 32'd0);
    apply_stimulus(1, 32'h4180_0000, 4'd7);
    wait_out(1, 40);
    check_output("post_rst_lat", 32'(cyc - acc_cyc[1]), 32'd17);
    idle(2);
    check_output("post_rst_sb_empty", 32'(exp_q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
